// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: default widths, canonical NOP and fetch FSM states.
package riscv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: imem request/response, redirect and decoder hand-off.
interface instr_fetch_if #(
  parameter int unsigned INSTR_WIDTH = riscv_pkg::INSTR_W,
  parameter int unsigned ADDR_WIDTH  = riscv_pkg::ADDR_W
);

  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [ADDR_WIDTH-1:0]  imem_req_addr;
  logic                   imem_rsp_valid;
  logic [INSTR_WIDTH-1:0] imem_rsp_data;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0]  instr_pc;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    input  instr_ready
  );

  // Memory / decoder / branch-unit side
  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Registered circular FIFO holding fetched {instruction, pc} entries with synchronous flush.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop & (r_count != '0);
  // A push into a full FIFO is only accepted when the head leaves in the same cycle
  assign w_push = i_push & ((r_count != FULL) | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PTR_W'(1);
      end
      r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order imem reads under a credit limit, buffers
// returned words for the decoder and discards stale responses after a redirect.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned           INSTR_WIDTH = INSTR_W,
  parameter int unsigned           ADDR_WIDTH  = ADDR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           DEPTH       = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = INSTR_WIDTH + ADDR_WIDTH;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  fetch_state_t          r_state;
  fetch_state_t          w_state_d;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_d;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      w_outstanding_d;
  logic [CNT_W-1:0]      w_out_after;
  logic [CNT_W-1:0]      r_drop_cnt;
  logic [CNT_W-1:0]      w_drop_cnt_d;
  logic                  r_run;

  logic [ADDR_WIDTH-1:0] r_pcq [DEPTH];
  logic [PTR_W-1:0]      r_pcq_wr;
  logic [PTR_W-1:0]      r_pcq_rd;

  logic                  w_req_valid;
  logic                  w_req_hs;
  logic                  w_rsp_owned;
  logic                  w_rsp_keep;
  logic                  w_rsp_drop;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [ENT_W-1:0]      w_fifo_data;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;

  assign w_redirect_pc = bus.redirect_pc & ~ADDR_WIDTH'(3);

  // r_run keeps the request line low while reset is asserted and for the first edge after
  assign w_req_valid = r_run & (r_state == FETCH) &
                       (({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < DEPTH_C);
  assign w_req_hs    = w_req_valid & bus.imem_req_ready;
  assign w_rsp_owned = bus.imem_rsp_valid & (r_drop_cnt == '0) & (r_outstanding != '0);
  assign w_rsp_keep  = w_rsp_owned & ~bus.redirect_valid;
  assign w_rsp_drop  = bus.imem_rsp_valid & (r_drop_cnt != '0);
  assign w_pop       = ~w_fifo_empty & bus.instr_ready;

  always_comb begin
    w_out_after     = r_outstanding + CNT_W'(w_req_hs) - CNT_W'(w_rsp_owned);
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_outstanding_d = w_out_after;
    w_drop_cnt_d    = r_drop_cnt - CNT_W'(w_rsp_drop);
    if (w_req_hs) begin
      w_pc_d = r_pc + ADDR_WIDTH'(4);
    end
    if ((r_state == DRAIN) && (w_drop_cnt_d == '0)) begin
      w_state_d = FETCH;
    end
    if (bus.redirect_valid) begin
      w_pc_d = w_redirect_pc;
      // Everything still in flight, including a request accepted right now, becomes stale
      if (r_state == FETCH) begin
        w_outstanding_d = '0;
        w_drop_cnt_d    = w_out_after;
        w_state_d       = (w_out_after != '0) ? DRAIN : FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_run         <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_outstanding <= w_outstanding_d;
      r_drop_cnt    <= w_drop_cnt_d;
      r_run         <= 1'b1;
    end
  end

  // PCs of live requests, matched to responses in issue order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pcq[i] <= '0;
      end
      r_pcq_wr <= '0;
      r_pcq_rd <= '0;
    end else if (bus.redirect_valid) begin
      r_pcq_wr <= '0;
      r_pcq_rd <= '0;
    end else begin
      if (w_req_hs) begin
        r_pcq[r_pcq_wr] <= r_pc;
        r_pcq_wr        <= r_pcq_wr + PTR_W'(1);
      end
      if (w_rsp_owned) begin
        r_pcq_rd <= r_pcq_rd + PTR_W'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rsp_keep),
    .i_data  ({bus.imem_rsp_data, r_pcq[r_pcq_rd]}),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.instr_valid    = ~w_fifo_empty;
  assign bus.instruction    = w_fifo_data[ENT_W-1:ADDR_WIDTH];
  assign bus.instr_pc       = w_fifo_data[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: in-order memory model plus a program-order
// reference of expected request addresses and delivered {instruction, pc} pairs.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus ();

  instr_fetch #(
    .INSTR_WIDTH (32),
    .ADDR_WIDTH  (32),
    .RESET_PC    (RESET_PC),
    .DEPTH       (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          issue;
  } req_t;

  req_t        memq[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          p_req_ready = 100;
  int          p_rsp = 100;
  int          p_instr_ready = 100;
  bit          g_redir = 0;
  logic [31:0] g_redir_pc = '0;
  logic [31:0] exp_req_addr, exp_pc, prev_addr;
  bit          prev_stall;
  bit          s_req_v, s_hs, s_rsp, s_instr_v, s_pop;
  logic [31:0] s_addr, s_instr, s_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic idle_inputs();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
  endtask

  // One clock: drive at negedge, sample 1 ns later, check against the model, advance.
  task automatic cycle();
    bus.imem_req_ready = roll(p_req_ready);
    bus.instr_ready    = roll(p_instr_ready);
    bus.redirect_valid = g_redir;
    bus.redirect_pc    = g_redir_pc;
    if (memq.size() > 0 && cyc >= memq[0].issue + 1 && roll(p_rsp)) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    s_req_v   = bus.imem_req_valid;
    s_addr    = bus.imem_req_addr;
    s_instr_v = bus.instr_valid;
    s_instr   = bus.instruction;
    s_ipc     = bus.instr_pc;
    s_rsp     = bus.imem_rsp_valid;
    s_hs      = s_req_v & bus.imem_req_ready;
    s_pop     = s_instr_v & bus.instr_ready;
    if (s_req_v) begin
      n_cmp++;
      if (s_addr[1:0] !== 2'b00) begin
        n_fail++;
        $display("FAIL addr_align: addr %h, low bits must be 00", s_addr);
      end
    end
    if (prev_stall) begin
      n_cmp++;
      if (s_req_v !== 1'b1 || s_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL req_hold: valid %b addr %h, required valid 1 addr %h",
                 s_req_v, s_addr, prev_addr);
      end
    end
    if (s_hs) begin
      n_cmp++;
      if (s_addr !== exp_req_addr) begin
        n_fail++;
        $display("FAIL req_addr: got %h required %h", s_addr, exp_req_addr);
      end
      exp_req_addr = exp_req_addr + 32'd4;
    end
    if (s_pop) begin
      n_cmp++;
      if (s_ipc !== exp_pc || s_instr !== mem_word(exp_pc)) begin
        n_fail++;
        $display("FAIL deliver: got (%h, pc %h) required (%h, pc %h)",
                 s_instr, s_ipc, mem_word(exp_pc), exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
    end
    if (g_redir) begin
      exp_req_addr = g_redir_pc & ~32'd3;
      exp_pc       = g_redir_pc & ~32'd3;
    end
    prev_stall = s_req_v & ~bus.imem_req_ready & ~g_redir;
    prev_addr  = s_addr;
    @(posedge clk);
    if (s_hs) memq.push_back('{addr: s_addr, issue: cyc});
    if (s_rsp) void'(memq.pop_front());
    cyc++;
    g_redir = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    memq.delete();
    repeat (2) @(negedge clk);
    rst_n        = 1'b1;
    exp_req_addr = RESET_PC;
    exp_pc       = RESET_PC;
    prev_stall   = 1'b0;
    g_redir      = 1'b0;
    p_req_ready  = 100;
    p_rsp        = 100;
    p_instr_ready = 100;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instruction !== '0 ||
        bus.instr_pc !== '0 || bus.imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_outputs: req_v %b instr_v %b instr %h ipc %h addr %h, required 0 0 0 0 %h",
               bus.imem_req_valid, bus.instr_valid, bus.instruction, bus.instr_pc,
               bus.imem_req_addr, RESET_PC);
    end
    do_reset();
  endtask

  task automatic test_basic();
    int          npop = 0;
    bit          seen = 0;
    bit          lat_pending = 0;
    logic [31:0] got_pc[2];
    logic [31:0] got_in[2];
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (lat_pending) begin
        lat_pending = 0;
        n_cmp++;
        if (s_instr_v !== 1'b1) begin
          n_fail++;
          $display("FAIL latency: instr_valid %b one cycle after first response, required 1",
                   s_instr_v);
        end
      end
      if (s_rsp && !seen) begin
        seen        = 1;
        lat_pending = 1;
        n_cmp++;
        if (s_instr_v !== 1'b0) begin
          n_fail++;
          $display("FAIL latency_early: instr_valid %b in response cycle, required 0", s_instr_v);
        end
      end
      if (s_pop && npop < 2) begin
        got_pc[npop] = s_ipc;
        got_in[npop] = s_instr;
        npop++;
      end
    end
    n_cmp++;
    if (npop < 2) begin
      n_fail++;
      $display("FAIL basic_timeout: %0d words delivered, required 2", npop);
    end else begin
      n_cmp++;
      if (got_in[0] !== 32'h0050_0093 || got_pc[0] !== 32'h0 ||
          got_in[1] !== 32'h0010_0113 || got_pc[1] !== 32'h4) begin
        n_fail++;
        $display("FAIL basic_words: got (%h,%h) (%h,%h) required (00500093,0) (00100113,4)",
                 got_in[0], got_pc[0], got_in[1], got_pc[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int nhs = 0;
    int npop = 0;
    do_reset();
    p_instr_ready = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_hs) nhs++;
    end
    n_cmp++;
    if (nhs > int'(DEPTH) || nhs == 0) begin
      n_fail++;
      $display("FAIL bp_credits: %0d requests while stalled, required 1..%0d", nhs, DEPTH);
    end
    n_cmp++;
    if (s_instr_v !== 1'b1 || s_addr !== 32'h8 || s_req_v !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: instr_v %b addr %h req_v %b, required 1 00000008 0",
               s_instr_v, s_addr, s_req_v);
    end
    p_instr_ready = 100;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (s_pop) npop++;
    end
    n_cmp++;
    if (npop < 2) begin
      n_fail++;
      $display("FAIL bp_release: %0d words after release, required at least 2", npop);
    end
  endtask

  task automatic test_redirect();
    int          nhs = 0;
    bit          got = 0;
    logic [31:0] first_pc = '0;
    do_reset();
    p_rsp = 0;
    for (int i = 0; i < 10 && nhs < 2; i++) begin
      cycle();
      if (s_hs) nhs++;
    end
    n_cmp++;
    if (nhs != 2) begin
      n_fail++;
      $display("FAIL redir_setup: %0d requests outstanding, required 2", nhs);
    end
    g_redir    = 1'b1;
    g_redir_pc = 32'h100;
    cycle();
    p_rsp = 100;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle();
      if (s_pop) begin
        got      = 1;
        first_pc = s_ipc;
      end
    end
    n_cmp++;
    if (!got || first_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_first: delivered %b pc %h, required 1 pc 00000100", got, first_pc);
    end
  endtask

  task automatic test_redirect_align();
    bit          got_hs = 0;
    bit          got_pop = 0;
    logic [31:0] hs_addr = '0;
    logic [31:0] pop_pc = '0;
    do_reset();
    p_req_ready = 0;
    p_rsp       = 0;
    repeat (3) cycle();
    g_redir    = 1'b1;
    g_redir_pc = 32'h40;
    cycle();
    p_req_ready = 100;
    g_redir     = 1'b1;
    g_redir_pc  = 32'h203;
    cycle();
    n_cmp++;
    if (s_hs !== 1'b1 || s_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL align_hs: hs %b addr %h, required 1 00000040", s_hs, s_addr);
    end
    p_rsp = 100;
    cycle();
    n_cmp++;
    if (s_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL align_addr: addr %h, required 00000200", s_addr);
    end
    for (int i = 0; i < 30 && !(got_hs && got_pop); i++) begin
      cycle();
      if (s_hs && !got_hs) begin
        got_hs  = 1;
        hs_addr = s_addr;
      end
      if (s_pop && !got_pop) begin
        got_pop = 1;
        pop_pc  = s_ipc;
      end
    end
    n_cmp++;
    if (!got_hs || hs_addr !== 32'h200 || !got_pop || pop_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL align_after: req %b %h pop %b pc %h, required 1 00000200 1 00000200",
               got_hs, hs_addr, got_pop, pop_pc);
    end
  endtask

  task automatic test_wrap();
    int          nhs = 0;
    logic [31:0] a[2];
    do_reset();
    g_redir    = 1'b1;
    g_redir_pc = 32'hFFFF_FFFC;
    cycle();
    for (int i = 0; i < 20 && nhs < 2; i++) begin
      cycle();
      if (s_hs) begin
        a[nhs] = s_addr;
        nhs++;
      end
    end
    n_cmp++;
    if (nhs < 2 || a[0] !== 32'hFFFF_FFFC || a[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap: %0d reqs, addrs %h %h, required fffffffc 00000000", nhs, a[0], a[1]);
    end
    repeat (10) cycle();
  endtask

  task automatic test_reset_drain();
    int  nhs = 0;
    bit  got = 0;
    do_reset();
    p_rsp = 0;
    for (int i = 0; i < 10 && nhs < 2; i++) begin
      cycle();
      if (s_hs) nhs++;
    end
    g_redir    = 1'b1;
    g_redir_pc = 32'h300;
    cycle();
    #2;
    rst_n = 1'b0;
    idle_inputs();
    memq.delete();
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instruction !== '0 ||
        bus.instr_pc !== '0 || bus.imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_drain: req_v %b instr_v %b instr %h ipc %h addr %h, required 0 0 0 0 %h",
               bus.imem_req_valid, bus.instr_valid, bus.instruction, bus.instr_pc,
               bus.imem_req_addr, RESET_PC);
    end
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 10 && !got; i++) begin
      cycle();
      if (s_hs) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL reset_drain_restart: no request after release, required addr %h", RESET_PC);
    end
    repeat (10) cycle();
  endtask

  task automatic test_random();
    int npop = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        p_req_ready   = int'($urandom_range(100, 30));
        p_rsp         = int'($urandom_range(100, 30));
        p_instr_ready = int'($urandom_range(100, 30));
      end
      if ($urandom_range(99) < 4) begin
        g_redir    = 1'b1;
        g_redir_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                              : $urandom;
      end
      cycle();
      if (s_pop) npop++;
    end
    n_cmp++;
    if (npop < 100) begin
      n_fail++;
      $display("FAIL random_progress: %0d words delivered, required at least 100", npop);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_redirect_align();
    test_wrap();
    test_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
